// File: rtl/piso_tx_pkg.sv
// piso_tx_pkg: shared state encoding and sizing helpers for the serial transmitter.
package piso_tx_pkg;
   typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
   localparam int DEF_WIDTH = 8;
   function automatic int cnt_w(input int width);
      return $clog2(width + 1);
   endfunction
endpackage

// File: rtl/piso_bit_cell.sv
// piso_bit_cell: one shift-register stage, parallel load or shift-in, async active-low reset.
module piso_bit_cell (
   input  logic clk,
   input  logic res,
   input  logic en,
   input  logic load,
   input  logic pin,
   input  logic sin,
   output logic q
);
   always_ff @(posedge clk or negedge res)
      if (!res) q <= 1'b0;
      else if (en) q <= load ? pin : sin;
endmodule

// File: rtl/piso_tx.sv
// piso_tx: framed parallel-to-serial transmitter with a ready/valid load port.
// Define PISO_TX_PARITY_EN to append an even-parity bit after the data bits.
module piso_tx
   import piso_tx_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             res,
   input  logic [WIDTH-1:0] din,
   input  logic             load_valid,
   output logic             load_ready,
   output logic             sout,
   output logic             sout_valid,
   output logic             frame,
   output logic             busy,
   output logic             done
);
   localparam int CW   = cnt_w(WIDTH);
   localparam int HEAD = MSB_FIRST ? WIDTH - 1 : 0;
`ifdef PISO_TX_PARITY_EN
   localparam state_t AFTER_DATA = PARITY;
`else
   localparam state_t AFTER_DATA = IDLE;
`endif
   state_t state, nxt;
   logic [CW-1:0] cnt;
   logic [WIDTH-1:0] sr, sin;
   logic accept, last, tail;

   assign accept = load_ready & load_valid;
   assign last   = cnt == CW'(WIDTH - 1);
   assign sin    = MSB_FIRST ? {sr[WIDTH-2:0], tail} : {tail, sr[WIDTH-1:1]};
   assign sout   = sr[HEAD];

`ifdef PISO_TX_PARITY_EN
   logic par;
   always_ff @(posedge clk or negedge res)
      if (!res) par <= 1'b0;
      else if (accept) par <= ^din;
   // Parity enters the tail on the first shift and reaches the head right after the last data bit.
   assign tail = par & (cnt == '0);
`else
   assign tail = 1'b0;
`endif

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      piso_bit_cell u_cell (
         .clk (clk),
         .res (res),
         .en  (accept | (state != IDLE)),
         .load(load_ready),
         .pin (din[i]),
         .sin (sin[i]),
         .q   (sr[i])
      );
   end

   always_ff @(posedge clk or negedge res)
      if (!res) begin
         state      <= IDLE;
         cnt        <= '0;
         sout_valid <= 1'b0;
         frame      <= 1'b0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= nxt;
         cnt        <= accept ? '0 : (state == SHIFT) ? cnt + 1'b1 : cnt;
         sout_valid <= nxt != IDLE;
         frame      <= accept;
         busy       <= nxt != IDLE;
         done       <= (state != IDLE) && (nxt == IDLE);
      end

   always_comb
      nxt = (state == IDLE)  ? (load_valid ? SHIFT : IDLE) :
            (state == SHIFT) ? (last ? AFTER_DATA : SHIFT) : IDLE;

   always_comb
      load_ready = state == IDLE;
endmodule
